// File: rtl/uart_tx_sched.sv
// Two-requester word scheduler feeding a byte-wide UART core.
// Words of 1..4 bytes are granted round-robin and sent one byte per ARM/ACK/DRAIN pass.
module uart_tx_sched #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [31:0]      req0_word,
  input  logic [1:0]       req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_word,
  input  logic [1:0]       req1_len,
  output logic             req1_ready,
  output logic             tx_ena,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  output logic             sched_busy,
  output logic             grant_id,
  output logic [CNT_W-1:0] words_sent
);

  typedef enum logic [1:0] {IDLE, ARM, ACK, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [31:0]        word_q, word_d;
  logic [1:0]         len_q, len_d;
  logic [1:0]         idx_q, idx_d;
  logic               grant_q, grant_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic [7:0]         data_q, data_d;
  logic               win0, win1;
  logic [31:0]        sel_word;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
    logic [1:0] lane;
    lane = MSB_FIRST ? (2'd3 - i) : i;
    case (lane)
      2'd0:    pick_byte = w[7:0];
      2'd1:    pick_byte = w[15:8];
      2'd2:    pick_byte = w[23:16];
      default: pick_byte = w[31:24];
    endcase
  endfunction

  // A requester wins if the other is idle or the other was served last.
  assign win0 = req0_valid & (~req1_valid | last_q);
  assign win1 = req1_valid & (~req0_valid | ~last_q);

  // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    len_d      = len_q;
    idx_d      = idx_q;
    grant_d    = grant_q;
    last_d     = last_q;
    sent_d     = sent_q;
    data_d     = data_q;
    sel_word   = win1 ? req1_word : req0_word;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    tx_ena     = 1'b0;

    case (state_q)
      IDLE: begin
        req0_ready = win0;
        req1_ready = win1;
        if (win0 | win1) begin
          word_d  = sel_word;
          len_d   = win1 ? req1_len : req0_len;
          grant_d = win1;
          last_d  = win1;
          idx_d   = 2'd0;
          data_d  = pick_byte(sel_word, 2'd0);
          state_d = ARM;
        end
      end
      ARM: begin
        if (!tx_busy) begin
          tx_ena  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (tx_busy) state_d = DRAIN;
      end
      DRAIN: begin
        if (!tx_busy) begin
          if (idx_q == len_q) begin
            sent_d  = sent_q + CNT_W'(1);
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            data_d  = pick_byte(word_q, idx_q + 2'd1);
            state_d = ARM;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset discards the word at once: no handshake and no strobe in the reset cycle.
    if (reset) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      tx_ena     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      sent_q  <= '0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      sent_q  <= sent_d;
      data_q  <= data_d;
    end
  end

  // NOTE: the latched word and length are pure datapath, only read after a fresh load, so they carry no reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    len_q  <= len_d;
  end

  assign tx_data    = data_q;
  assign sched_busy = (state_q != IDLE);
  assign grant_id   = grant_q;
  assign words_sent = sent_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: an MSB-first/16-bit instance and an LSB-first/4-bit instance share stimulus,
// a word-level model checks both every cycle, and literal expectations pin the model.
module tb_uart_tx_sched;

  localparam int BUSY_CYC = 10;

  logic        clk, reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_word, req1_word;
  logic [1:0]  req0_len, req1_len;
  logic        tx_busy, busy_force;

  logic        r0_a, r1_a, ena_a, sbusy_a, grant_a;
  logic [7:0]  data_a;
  logic [15:0] ws_a;
  logic        r0_b, r1_b, ena_b, sbusy_b, grant_b;
  logic [7:0]  data_b;
  logic [3:0]  ws_b;

  uart_tx_sched #(.MSB_FIRST(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_word(req0_word), .req0_len(req0_len), .req0_ready(r0_a),
    .req1_valid(req1_valid), .req1_word(req1_word), .req1_len(req1_len), .req1_ready(r1_a),
    .tx_ena(ena_a), .tx_data(data_a), .tx_busy(tx_busy),
    .sched_busy(sbusy_a), .grant_id(grant_a), .words_sent(ws_a)
  );

  uart_tx_sched #(.MSB_FIRST(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_word(req0_word), .req0_len(req0_len), .req0_ready(r0_b),
    .req1_valid(req1_valid), .req1_word(req1_word), .req1_len(req1_len), .req1_ready(r1_b),
    .tx_ena(ena_b), .tx_data(data_b), .tx_busy(tx_busy),
    .sched_busy(sbusy_b), .grant_id(grant_b), .words_sent(ws_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART core: busy for BUSY_CYC cycles after each strobe, or forced high by the stimulus.
  initial begin
    int cnt;
    cnt = 0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ena_a) cnt = BUSY_CYC;
      @(posedge clk);
      #2;
      tx_busy = busy_force || (cnt > 0);
      if (cnt > 0) cnt--;
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Word-level model
  bit          m_active, m_pending, m_seen_high, m_grant, m_last;
  logic [31:0] m_word;
  int          m_len, m_idx, m_sent;
  bit          acc0, acc1;
  logic [7:0]  log_a[$];
  logic [7:0]  log_b[$];
  int          ena_cyc[$];
  int          acc_cyc[$];
  bit          grant_log[$];

  function automatic logic [7:0] byte_msb(input logic [31:0] w, input int i);
    return 8'((w >> (24 - 8 * i)) & 32'hFF);
  endfunction

  function automatic logic [7:0] byte_lsb(input logic [31:0] w, input int i);
    return 8'((w >> (8 * i)) & 32'hFF);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit er0, er1, eena;
    cyc++;
    if (reset) begin
      check("rst_ready0_a", 32'(r0_a), 0);
      check("rst_ready1_a", 32'(r1_a), 0);
      check("rst_ready0_b", 32'(r0_b), 0);
      check("rst_ready1_b", 32'(r1_b), 0);
      check("rst_ena_a", 32'(ena_a), 0);
      check("rst_ena_b", 32'(ena_b), 0);
      m_active = 0; m_pending = 0; m_seen_high = 0;
      m_grant = 0; m_last = 1; m_sent = 0; m_idx = 0;
      return;
    end
    er0  = !m_active && req0_valid && (!req1_valid || m_last);
    er1  = !m_active && req1_valid && (!req0_valid || !m_last);
    eena = m_active && m_pending && !tx_busy;
    check("ready0_a", 32'(r0_a), 32'(er0));
    check("ready1_a", 32'(r1_a), 32'(er1));
    check("ready0_b", 32'(r0_b), 32'(er0));
    check("ready1_b", 32'(r1_b), 32'(er1));
    check("ena_a", 32'(ena_a), 32'(eena));
    check("ena_b", 32'(ena_b), 32'(eena));
    check("sched_busy_a", 32'(sbusy_a), 32'(m_active));
    check("sched_busy_b", 32'(sbusy_b), 32'(m_active));
    check("grant_a", 32'(grant_a), 32'(m_grant));
    check("grant_b", 32'(grant_b), 32'(m_grant));
    check("words_a", 32'(ws_a), 32'(m_sent % 65536));
    check("words_b", 32'(ws_b), 32'(m_sent % 16));
    if (eena || (m_active && !m_pending)) begin
      check("data_a", 32'(data_a), 32'(byte_msb(m_word, m_idx)));
      check("data_b", 32'(data_b), 32'(byte_lsb(m_word, m_idx)));
    end
    if (ena_a) begin
      log_a.push_back(data_a);
      ena_cyc.push_back(cyc);
    end
    if (ena_b) log_b.push_back(data_b);

    if (!m_active) begin
      if (er0 || er1) begin
        m_active  = 1;
        m_grant   = er1;
        m_last    = er1;
        m_word    = er1 ? req1_word : req0_word;
        m_len     = er1 ? int'(req1_len) : int'(req0_len);
        m_idx     = 0;
        m_pending = 1;
        grant_log.push_back(er1);
        acc_cyc.push_back(cyc);
        acc0 = er0;
        acc1 = er1;
      end
    end else if (m_pending) begin
      if (!tx_busy) begin
        m_pending   = 0;
        m_seen_high = 0;
      end
    end else if (!m_seen_high) begin
      if (tx_busy) m_seen_high = 1;
    end else if (!tx_busy) begin
      if (m_idx == m_len) begin
        m_sent++;
        m_active = 0;
      end else begin
        m_idx++;
        m_pending = 1;
      end
    end
  endtask

  // Compare at the falling edge, then return just after the next rising edge for new stimulus.
  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_a.delete(); log_b.delete(); ena_cyc.delete(); acc_cyc.delete(); grant_log.delete();
  endtask

  task automatic send(input bit r, input logic [31:0] w, input logic [1:0] l);
    int n;
    acc0 = 0;
    acc1 = 0;
    if (r) begin
      req1_valid = 1'b1; req1_word = w; req1_len = l;
    end else begin
      req0_valid = 1'b1; req0_word = w; req0_len = l;
    end
    n = 0;
    while (!(r ? acc1 : acc0) && n < 200) begin
      cycle();
      n++;
    end
    check("accept_in_time", 32'(r ? acc1 : acc0), 1);
    if (r) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_active && n < 500) begin
      cycle();
      n++;
    end
    check("idle_in_time", 32'(m_active), 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; busy_force = 1'b0;
    req0_valid = 1'b0; req0_word = '0; req0_len = '0;
    req1_valid = 1'b0; req1_word = '0; req1_len = '0;

    // Reset state
    do_reset(3);
    cycle();
    check("lit_rst_data_a", 32'(data_a), 32'h00);
    check("lit_rst_words_a", 32'(ws_a), 0);
    check("lit_rst_grant_a", 32'(grant_a), 0);

    // Four-byte word, MSB first on dut_a, LSB first on dut_b
    clear_logs();
    send(1'b0, 32'h41424344, 2'd3);
    wait_idle();
    check("lit_w4_count", 32'(log_a.size()), 4);
    check("lit_w4_b0", 32'(log_a[0]), 32'h41);
    check("lit_w4_b1", 32'(log_a[1]), 32'h42);
    check("lit_w4_b2", 32'(log_a[2]), 32'h43);
    check("lit_w4_b3", 32'(log_a[3]), 32'h44);
    check("lit_w4_lsb_b0", 32'(log_b[0]), 32'h44);
    check("lit_latency", 32'(ena_cyc[0] - acc_cyc[0]), 1);
    check("lit_w4_words", 32'(ws_a), 1);

    // Single byte from requester 1
    clear_logs();
    send(1'b1, 32'hAABBCCDD, 2'd0);
    wait_idle();
    check("lit_w1_count", 32'(log_b.size()), 1);
    check("lit_w1_lsb", 32'(log_b[0]), 32'hDD);
    check("lit_w1_msb", 32'(log_a[0]), 32'hAA);
    check("lit_w1_idle", 32'(sbusy_b), 0);

    // Core busy when the word is accepted
    clear_logs();
    busy_force = 1'b1;
    send(1'b0, 32'h11223344, 2'd0);
    for (int i = 0; i < 5; i++) cycle();
    check("lit_hold_no_ena", 32'(log_a.size()), 0);
    busy_force = 1'b0;
    cycle();
    check("lit_hold_fire", 32'(log_a.size()), 1);
    check("lit_hold_data_a", 32'(log_a[0]), 32'h11);
    check("lit_hold_data_b", 32'(log_b[0]), 32'h44);
    wait_idle();

    // Both requesters valid from reset
    req0_valid = 1'b1; req0_word = 32'h000000A0; req0_len = 2'd0;
    req1_valid = 1'b1; req1_word = 32'h000000B1; req1_len = 2'd0;
    do_reset(1);
    clear_logs();
    n = 0;
    while (grant_log.size() < 4 && n < 400) begin
      cycle();
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("lit_rr_count", 32'(grant_log.size()), 4);
    check("lit_rr_g0", 32'(grant_log[0]), 0);
    check("lit_rr_g1", 32'(grant_log[1]), 1);
    check("lit_rr_g2", 32'(grant_log[2]), 0);
    check("lit_rr_g3", 32'(grant_log[3]), 1);
    wait_idle();

    // Reset during DRAIN of byte 1
    clear_logs();
    send(1'b0, 32'h55667788, 2'd3);
    n = 0;
    while (log_a.size() < 2 && n < 200) begin
      cycle();
      n++;
    end
    cycle();
    check("lit_mid_in_drain", 32'(sbusy_a && tx_busy), 1);
    do_reset(1);
    cycle();
    check("lit_mid_data_a", 32'(data_a), 32'h00);
    check("lit_mid_data_b", 32'(data_b), 32'h00);
    check("lit_mid_words", 32'(ws_a), 0);
    check("lit_mid_busy", 32'(sbusy_a), 0);
    for (int i = 0; i < 20; i++) cycle();
    check("lit_mid_no_ena", 32'(log_a.size()), 2);

    // Counter wrap on the 4-bit instance
    do_reset(1);
    for (int i = 0; i < 17; i++) begin
      send(i[0], 32'h00000010 + 32'(i), 2'd0);
      wait_idle();
    end
    check("lit_wrap_b", 32'(ws_b), 1);
    check("lit_wrap_a", 32'(ws_a), 17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 The block SHALL provide parameter MSB_FIRST, default 1: 1 sends word[31:24] first, 0 sends word[7:0] first.
REQ-002 The block SHALL provide parameter CNT_W, default 16: width of the sent-word counter.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0_valid  in  1  requester 0 (CPU MMIO path) has a word.
REQ-006 req0_word  in  32  requester 0 data.
REQ-007 req0_len  in  2  requester 0 byte count minus 1 (0 = 1 byte, 3 = 4 bytes).
REQ-008 req0_ready  out  1  requester 0 word accepted this cycle when high with req0_valid.
REQ-009 req1_valid, req1_word, req1_len, req1_ready  SHALL mirror REQ-005..008 for requester 1 (debug/trace path).
REQ-010 tx_ena  out  1  one-cycle send strobe to the UART core.
REQ-011 tx_data  out  8  byte to the UART core.
REQ-012 tx_busy  in  1  UART core busy, high while a byte is shifting.
REQ-013 sched_busy  out  1  high whenever state is not IDLE.
REQ-014 grant_id  out  1  requester owning the current word; holds last value in IDLE.
REQ-015 words_sent  out  CNT_W  count of fully transmitted words, wraps modulo 2^CNT_W.

Function
REQ-016 States SHALL be IDLE, ARM, ACK and DRAIN.
REQ-017 In IDLE, ready SHALL be combinational: req0_ready = req0_valid & (~req1_valid | last_grant==1); req1_ready = req1_valid & (~req0_valid | last_grant==0); both low outside IDLE.
REQ-018 On a transfer (valid & ready), the block SHALL latch word and len, set grant_id and last_grant to the winner, clear byte index, and go to ARM.
REQ-019 ARM: if tx_busy==0, tx_ena SHALL be 1 for exactly this cycle with tx_data = selected byte, then go to ACK; if tx_busy==1, stay in ARM with tx_ena 0.
REQ-020 ACK: stay until tx_busy==1, then go to DRAIN; tx_ena SHALL stay 0.
REQ-021 DRAIN: on tx_busy==0, if byte index == len, increment words_sent and go to IDLE; else increment byte index and go to ARM.
REQ-022 Byte selection: with MSB_FIRST=1, index i SHALL send word[31-8i -: 8]; with MSB_FIRST=0, word[8i+7 -: 8].
REQ-023 tx_data SHALL be held stable from the tx_ena cycle until the DRAIN exit for that byte.
REQ-024 Latency: word accepted in cycle N with tx_busy low SHALL produce tx_ena in cycle N+1.
REQ-025 A requester that stays valid SHALL be served after at most one word from the other requester (round-robin, no starvation).
REQ-026 tx_busy changes in IDLE SHALL have no effect; at most one tx_ena per transmitted byte.
REQ-027 Requester inputs SHALL be ignored outside IDLE; latched word and len SHALL not change until IDLE.

Reset
REQ-028 On reset, the block SHALL go to IDLE with tx_ena=0, tx_data=8'h00, grant_id=0, last_grant=1, words_sent=0, byte index=0, and both ready outputs low.
REQ-029 Reset in any state SHALL discard the latched word with no further tx_ena; a byte already in the UART core is not recalled.

Verification
REQ-030 req0 word 32'h41424344, len 3, MSB_FIRST=1, UART model busy 10 cycles per byte -> tx_data 8'h41, 8'h42, 8'h43, 8'h44 in order; one tx_ena per byte; words_sent=1.
REQ-031 req0 and req1 both valid continuously from reset -> grants alternate 0,1,0,1; first grant is 0.
REQ-032 req1 len 0, word 32'hAABBCCDD, MSB_FIRST=0 -> single tx_ena with tx_data 8'hDD; return to IDLE after busy falls.
REQ-033 tx_busy held high when a word is accepted -> tx_ena stays 0 in ARM until tx_busy drops, then fires the next cycle.
REQ-034 reset asserted in DRAIN of byte 1 of a 4-byte word -> no further tx_ena; all REQ-028 values hold the next cycle; words_sent=0.
REQ-035 CNT_W=4 with 17 single-byte words -> words_sent reads 1 (wrap).
